// File: rtl/tcam_pkg.sv
// Shared constants and entry layout for the 16x16 ternary CAM.
package tcam_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  // A mask bit of 1 marks the matching data bit as don't-care.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] mask;
    logic             valid;
  } entry_t;

endpackage

// File: rtl/tcam_pri_enc.sv
// Priority encoder: reports the lowest-index set bit of the hit vector.
module tcam_pri_enc
  import tcam_pkg::*;
(
  input  logic [DEPTH-1:0]  hits,
  output logic [ADDR_W-1:0] index,
  output logic              any_hit
);

  // Scanning downward lets the lowest set index win.
  always_comb begin
    index   = '0;
    any_hit = |hits;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hits[i]) begin
        index = ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/tcam.sv
// Ternary CAM: entry storage, parallel compare and registered search result.
module tcam
  import tcam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              r_e,
  input  logic              w_e,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  mask,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [WIDTH-1:0]  matched_num,
  output logic              match
);

  entry_t            entries [DEPTH];
  logic [DEPTH-1:0]  hits;
  logic [ADDR_W-1:0] hit_index;
  logic              any_hit;

  // Compares use the pre-edge contents, so a same-cycle write is seen next cycle.
  always_comb begin
    hits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hits[i] = entries[i].valid &&
                (&(~(data_in ^ entries[i].data) | entries[i].mask));
    end
  end

  tcam_pri_enc u_pri_enc (
    .hits    (hits),
    .index   (hit_index),
    .any_hit (any_hit)
  );

  // Only valid flags are reset; stored words stay hidden until rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
      match       <= 1'b0;
      matched_num <= '0;
    end else begin
      if (w_e) begin
        entries[addr_in] <= '{data: data_in, mask: mask, valid: 1'b1};
      end
      if (r_e) begin
        match       <= any_hit;
        matched_num <= any_hit ? entries[hit_index].data : '0;
      end
    end
  end

endmodule

// File: tb/tb_tcam.sv
// Self-checking bench for tcam using a reference table model and a result scoreboard.
module tb_tcam;

  logic        clk;
  logic        rst;
  logic        r_e;
  logic        w_e;
  logic [15:0] data_in;
  logic [15:0] mask;
  logic [3:0]  addr_in;
  logic [15:0] matched_num;
  logic        match;

  typedef struct {
    logic        m;
    logic [15:0] n;
  } exp_t;

  exp_t        sb_queue[$];
  logic [15:0] m_data  [16];
  logic [15:0] m_mask  [16];
  logic        m_valid [16];
  logic        exp_match;
  logic [15:0] exp_num;
  int          assertions;
  int          failures;

  tcam dut (
    .clk         (clk),
    .rst         (rst),
    .r_e         (r_e),
    .w_e         (w_e),
    .data_in     (data_in),
    .mask        (mask),
    .addr_in     (addr_in),
    .matched_num (matched_num),
    .match       (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
    end
  endtask

  // Reference search: scan the model table bit by bit, first valid hit wins.
  task automatic modelSearch(input logic [15:0] key);
    logic found;
    logic ok;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ok = m_valid[i];
      for (int b = 0; b < 16; b++) begin
        if (!m_mask[i][b] && (key[b] != m_data[i][b])) ok = 1'b0;
      end
      if (ok && !found) begin
        found     = 1'b1;
        exp_match = 1'b1;
        exp_num   = m_data[i];
      end
    end
    if (!found) begin
      exp_match = 1'b0;
      exp_num   = 16'h0000;
    end
  endtask

  task automatic applyStimulus(input logic i_rst, input logic i_re, input logic i_we,
                               input logic [3:0] i_addr, input logic [15:0] i_data,
                               input logic [15:0] i_mask, input string tag);
    exp_t e;
    rst     = i_rst;
    r_e     = i_re;
    w_e     = i_we;
    addr_in = i_addr;
    data_in = i_data;
    mask    = i_mask;
    if (i_rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      exp_match = 1'b0;
      exp_num   = 16'h0000;
    end else begin
      if (i_re) modelSearch(i_data);
      if (i_we) begin
        m_data[i_addr]  = i_data;
        m_mask[i_addr]  = i_mask;
        m_valid[i_addr] = 1'b1;
      end
    end
    e.m = exp_match;
    e.n = exp_num;
    sb_queue.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r_e = 1'b0;
    w_e = 1'b0;
    if (sb_queue.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 16'h0001, 16'h0000);
    end else begin
      e = sb_queue.pop_front();
      checkOutput({tag, "_match"}, {15'h0, match}, {15'h0, e.m});
      checkOutput({tag, "_num"}, matched_num, e.n);
    end
  endtask

  task automatic doWrite(input logic [3:0] a, input logic [15:0] d, input logic [15:0] m,
                         input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, a, d, m, tag);
  endtask

  task automatic doSearch(input logic [15:0] key, input string tag);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, key, 16'h0000, tag);
  endtask

  initial begin
    logic [15:0] pool [4];
    logic [15:0] mpool [4];
    assertions = 0;
    failures   = 0;
    exp_match  = 1'b0;
    exp_num    = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 16'h0000;
      m_mask[i]  = 16'h0000;
    end
    rst = 1'b1; r_e = 1'b0; w_e = 1'b0;
    addr_in = 4'h0; data_in = 16'h0000; mask = 16'h0000;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, "reset");
    doSearch(16'h0000, "empty_search");

    doWrite(4'd0, 16'hABCD, 16'h0F0F, "wr_e0");
    doWrite(4'd1, 16'hCDEF, 16'hFF00, "wr_e1");
    doWrite(4'd2, 16'h50C9, 16'hC32C, "wr_e2");
    doSearch(16'hAFC2, "hit_e0");
    doSearch(16'hD3C9, "hit_e2");
    doSearch(16'hCDFE, "miss");

    doWrite(4'd3, 16'h1234, 16'hFFFF, "wr_e3_wild");
    doWrite(4'd1, 16'h1234, 16'h0000, "wr_e1_exact");
    doSearch(16'h1234, "prio_e1");
    doWrite(4'd1, 16'h0000, 16'h0000, "rewr_e1");
    doSearch(16'h1234, "prio_e3");

    doWrite(4'd3, 16'h0000, 16'h0000, "hold_wr_e3");
    doWrite(4'd8, 16'hBEEF, 16'h0000, "hold_wr_e8");
    doWrite(4'd9, 16'h1234, 16'h0000, "hold_wr_e9");

    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 16'h7777, 16'h0000, "rw_same_cycle");
    doSearch(16'h7777, "rw_next_search");

    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, "mid_reset");
    doSearch(16'h7777, "post_reset_search");

    pool[0] = 16'h1234; pool[1] = 16'h12F4; pool[2] = 16'hA5A5; pool[3] = 16'h0000;
    mpool[0] = 16'h0000; mpool[1] = 16'h00F0; mpool[2] = 16'hFF00; mpool[3] = 16'hFFFF;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
                    pool[$urandom_range(0, 3)], mpool[$urandom_range(0, 3)], "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/tcam.md
Name: tcam

Overview:
- 16-entry × 16-bit ternary content-addressable memory.
- Each entry holds a data word, a per-bit don't-care mask and a valid flag.
- A registered search compares a key against all valid entries in parallel and returns the stored word of the highest-priority (lowest-index) hit plus a hit flag.
- Used as a lookup/classification table by a host that writes entries by address and issues single-cycle search strobes.

Parameters:
- WIDTH, 16, bit width of data word, mask, key and matched_num.
- DEPTH, 16, number of entries; address width is log2(DEPTH) = 4.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- r_e  input  1  search strobe; sampled on rising clk.
- w_e  input  1  write strobe; sampled on rising clk.
- data_in  input  WIDTH  write data when w_e; search key when r_e.
- mask  input  WIDTH  write mask; bit=1 means don't-care for that bit. Ignored when w_e=0.
- addr_in  input  4  entry index for writes. Ignored for searches.
- matched_num  output  WIDTH  stored data word of lowest-index matching entry; registered.
- match  output  1  1 = at least one valid entry matched the last search; registered.

Behaviour:
- Reset (rst=1 at rising clk):
  - All valid flags clear; match=0; matched_num=0.
  - Entry data/mask contents need no reset; they are never observable while invalid.
  - rst overrides r_e/w_e in the same cycle.
- Write (w_e=1 at rising clk):
  - entry[addr_in] ← {data_in, mask, valid=1}.
  - Overwriting a valid entry replaces it completely.
  - Data bits under mask=1 are stored unchanged; they have no effect on compares.
- Entry hit rule: entry i hits iff valid[i] and ((key XNOR data[i]) OR mask[i]) is all ones. An all-ones mask matches any key.
- Search (r_e=1 at rising clk), 1-cycle latency; outputs visible after that edge:
  - Any hit: match=1, matched_num = data[i] of the lowest i that hits.
  - No hit: match=0, matched_num=0.
- Output hold: when r_e=0, match and matched_num keep their values until the next search or reset. Writes alone never change the outputs.
- Simultaneous r_e and w_e: both are performed. The search compares against contents before that edge (read-before-write); the new entry is visible from the next cycle.
- No busy/stall: a search or write is accepted every cycle.
- Invalid entries never match, including key 0x0000 against never-written entries.

Decomposition:
- Shared package tcam_pkg: WIDTH, DEPTH, ADDR_W constants; entry struct typedef {data, mask, valid}.
- One sub-module, tcam_pri_enc: DEPTH-bit hit vector → lowest set index + any-hit flag.
- Top module holds the storage array, the per-entry compare logic and the output registers.

Test Plan:
- Reset, then search 0x0000 with no writes → match=0, matched_num=0x0000.
- Write e0={0xABCD, mask 0x0F0F}, e1={0xCDEF, 0xFF00}, e2={0x50C9, 0xC32C}; search 0xAFC2 → match=1, matched_num=0xABCD.
- Same table, search 0xD3C9 → match=1, matched_num=0x50C9. Search 0xCDFE → match=0, matched_num=0x0000.
- Priority: write e3={0x1234, 0xFFFF} and e1={0x1234, 0x0000}; search 0x1234 → matched_num=0x1234 from e1 (lowest index). Then rewrite e1 to {0x0000, 0x0000}; search 0x1234 → e3 hits, match=1.
- Hold and simultaneity:
  - After a hit, drop r_e for 3 cycles while writing other entries → outputs unchanged.
  - Same-cycle r_e+w_e writing key 0x7777 into e5 (no prior match) → match=0; a search on the next cycle → match=1.
- Reset mid-operation: with match=1, assert rst → match=0, matched_num=0. A following search for a previously stored key → match=0.
